// File: rtl/e203_itcm_ram_ctrl.sv
// ---------------------------------------------------------------------------
// e203_itcm_ram_ctrl
//
// Bridges a single-outstanding ICB command/response channel onto a
// single-port synchronous RAM. Each accepted command is issued to the RAM in
// the same cycle. Its response is presented in the following cycle. An idle
// counter parks the RAM in light sleep after IDLE_LS_CYC quiet cycles. A new
// command wakes it through a one-cycle WAKE state.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   icb_cmd_valid/ready        command handshake
//   icb_cmd_read/addr/wdata/wmask  command payload (word address, byte mask)
//   icb_rsp_valid/ready        response handshake
//   icb_rsp_rdata              read data (0 on write responses)
//   ram_cs/we/addr/wem/din     combinational RAM access port
//   ram_dout                   RAM read data, valid the cycle after a read
//   ram_ls                     light sleep request; ram_ds/ram_sd tied low
// ---------------------------------------------------------------------------
module e203_itcm_ram_ctrl #(
  parameter int AW          = 13,
  parameter int DW          = 64,
  parameter int MW          = 8,
  parameter int IDLE_LS_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic          icb_cmd_read,
  input  logic [AW-1:0] icb_cmd_addr,
  input  logic [DW-1:0] icb_cmd_wdata,
  input  logic [MW-1:0] icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [DW-1:0] icb_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);

  typedef enum logic [1:0] {ST_RUN, ST_SLEEP, ST_WAKE} state_e;

  localparam logic [7:0] IDLE_MAX = 8'(IDLE_LS_CYC);

  state_e        state_q, state_d;
  logic [7:0]    idle_cnt_q, idle_cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_is_read_q, rsp_is_read_d;
  // High in the first cycle a response is presented, when ram_dout still
  // carries the data of the access that produced it.
  logic          rsp_first_q, rsp_first_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          cmd_accept;

  // Ready is forced high while in reset. Any handshake seen then is
  // discarded by the reset branch of the state register.
  assign icb_cmd_ready = ~rst_n |
                         ((state_q == ST_RUN) & (~rsp_valid_q | icb_rsp_ready));
  assign cmd_accept    = icb_cmd_valid & icb_cmd_ready;

  assign ram_cs   = cmd_accept;
  assign ram_we   = cmd_accept & ~icb_cmd_read;
  assign ram_addr = icb_cmd_addr;
  assign ram_din  = icb_cmd_wdata;
  assign ram_wem  = icb_cmd_read ? '0 : icb_cmd_wmask;

  assign ram_ls = (state_q == ST_SLEEP);
  assign ram_ds = 1'b0;
  assign ram_sd = 1'b0;

  assign icb_rsp_valid = rsp_valid_q;
  // The first response cycle bypasses the RAM output. Later cycles of a
  // stalled response use the captured copy because ram_dout may move on.
  assign icb_rsp_rdata = ~rsp_is_read_q ? '0 : (rsp_first_q ? ram_dout : hold_q);

  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_is_read_d = rsp_is_read_q;
    rsp_first_d   = 1'b0;
    hold_d        = hold_q;

    // A new accept wins over a simultaneous drain, so back-to-back accesses
    // keep rsp_valid high.
    if (cmd_accept) begin
      rsp_valid_d   = 1'b1;
      rsp_is_read_d = icb_cmd_read;
      rsp_first_d   = 1'b1;
    end else if (icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (rsp_valid_q & rsp_first_q & rsp_is_read_q & ~icb_rsp_ready) begin
      hold_d = ram_dout;
    end

    unique case (state_q)
      ST_RUN: begin
        if (cmd_accept | rsp_valid_q) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q < IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
        // The counter can only sit at IDLE_MAX with no response pending.
        if ((idle_cnt_q == IDLE_MAX) & ~icb_cmd_valid) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        idle_cnt_d = '0;
        if (icb_cmd_valid) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        idle_cnt_d = '0;
        state_d    = ST_RUN;
      end
      default: begin
        idle_cnt_d = '0;
        state_d    = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      idle_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_is_read_q <= 1'b0;
      rsp_first_q   <= 1'b0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_is_read_q <= rsp_is_read_d;
      rsp_first_q   <= rsp_first_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: doc/e203_itcm_ram_ctrl.md
E203_ITCM_RAM_CTRL -- requirements
Module: e203_itcm_ram_ctrl

Interface
REQ-001 Parameters SHALL be: AW, 13, RAM word-address width; DW, 64, data width; MW, 8, byte-mask width (DW/8); IDLE_LS_CYC, 16, idle cycles before light sleep (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 icb_cmd_valid  input  1  command request.
REQ-005 icb_cmd_ready  output  1  command accept.
REQ-006 icb_cmd_read  input  1  1 = read, 0 = write.
REQ-007 icb_cmd_addr  input  AW  RAM word address.
REQ-008 icb_cmd_wdata  input  DW  write data.
REQ-009 icb_cmd_wmask  input  MW  write byte enables.
REQ-010 icb_rsp_valid  output  1  response valid.
REQ-011 icb_rsp_ready  input  1  response accept.
REQ-012 icb_rsp_rdata  output  DW  read data; 0 for write responses.
REQ-013 ram_cs, ram_we  output  1 each  RAM chip select, write enable.
REQ-014 ram_addr  output  AW; ram_wem  output  MW; ram_din  output  DW  RAM address, byte mask, write data.
REQ-015 ram_dout  input  DW  RAM read data, valid the cycle after a read access.
REQ-016 ram_ls  output  1  light sleep; ram_ds, ram_sd  output  1 each, tied 0.

Function
REQ-017 Handshake: a command is accepted when icb_cmd_valid & icb_cmd_ready; at most one response is outstanding.
REQ-018 In state RUN, icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready (back-to-back accesses allowed when the response drains each cycle).
REQ-019 ram_cs = accept; ram_we = accept & ~icb_cmd_read; ram_addr = icb_cmd_addr; ram_din = icb_cmd_wdata; ram_wem = icb_cmd_read ? 0 : icb_cmd_wmask; all combinational.
REQ-020 Latency: a command accepted in cycle N SHALL give icb_rsp_valid = 1 in cycle N+1.
REQ-021 A response SHALL stay valid, with stable rdata, until icb_rsp_ready is sampled high.
REQ-022 Read response in its first valid cycle: icb_rsp_rdata = ram_dout (bypass).
REQ-023 If that response is not accepted, ram_dout SHALL be captured into a hold register at the end of that cycle; rdata comes from the hold register until accepted.
REQ-024 Write responses SHALL carry rdata = 0, using a registered rsp_is_read flag.
REQ-025 Simultaneous rsp accept and new cmd accept in one cycle: icb_rsp_valid stays 1 and the next cycle presents the new response.
REQ-026 FSM states RUN, SLEEP and WAKE.
REQ-027 RUN, idle counter: 8-bit; increments each cycle with no accept and icb_rsp_valid = 0; clears on any accept or while icb_rsp_valid = 1; saturates at IDLE_LS_CYC.
REQ-028 RUN -> SLEEP when the counter equals IDLE_LS_CYC and icb_cmd_valid = 0 in that cycle.
REQ-029 SLEEP: ram_ls = 1, icb_cmd_ready = 0, ram_cs = 0.
REQ-030 SLEEP -> WAKE when icb_cmd_valid = 1.
REQ-031 WAKE: ram_ls = 0, icb_cmd_ready = 0; lasts exactly one cycle, then RUN with the counter cleared.
REQ-032 A command pending on entry to SLEEP SHALL be accepted 2 cycles after its valid is first seen in SLEEP.

Reset
REQ-033 While rst_n = 0 at a clock edge: state = RUN, idle counter = 0, icb_rsp_valid = 0, hold register = 0, rsp_is_read = 0, ram_ls = 0.
REQ-034 The outputs in REQ-019 SHALL stay combinational through reset; icb_cmd_ready = 1 during reset, so any accept during reset is ignored.
REQ-035 Reset asserted with a response outstanding SHALL drop it; no response is produced after reset deasserts.

Verification
REQ-036 Write addr 0x005, wdata 0x1122334455667788, wmask 0xFF; read addr 0x005 -> read rsp in cycle N+1 with rdata 0x1122334455667788; write rsp rdata = 0.
REQ-037 Read with icb_rsp_ready = 0 for 3 cycles while ram_dout changes to 0xDEAD -> rdata holds the original value, icb_cmd_ready = 0, no ram_cs until accepted.
REQ-038 4 back-to-back reads with icb_rsp_ready = 1 -> ram_cs high 4 consecutive cycles, 4 consecutive rsp cycles, no bubbles.
REQ-039 Idle 16 cycles -> ram_ls = 1 from cycle 17; then cmd_valid -> WAKE (ls = 0, ready = 0) one cycle, accept the following cycle.
REQ-040 Partial write wmask 0x0F of 0xFFFFFFFF_FFFFFFFF over 0 -> readback 0x00000000_FFFFFFFF.
REQ-041 Reset pulsed with a response pending -> icb_rsp_valid = 0 after the edge, counter = 0, ram_ls = 0.
